// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline for ID/EX, EX/MEM and MEM/WB: carries decoded control
// bundles, detects load-use and taken-branch hazards, and selects EX operand forwarding.

module ctrl_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic              i_mem_ok,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_wb_ok,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [REG_AW-1:0] i_rs,
    output logic [1:0]        o_sel
);
    // i_*_ok already excludes x0 writers, so a zero index can never be forwarded.
    always_comb begin
        o_sel = 2'b00;
        if (i_mem_ok && (i_mem_rd == i_rs))
            o_sel = 2'b01;
        else if (i_wb_ok && (i_wb_rd == i_rs))
            o_sel = 2'b10;
    end
endmodule

module ctrl_pipe_hazard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [3:0]        id_ALUOp,
    input  logic [4:0]        id_BrOp,
    input  logic [2:0]        id_DMCtrl,
    input  logic [1:0]        id_RUDataWrSrc,
    input  logic              id_RuWr,
    input  logic              id_DMWr,
    input  logic              id_AluASrc,
    input  logic              id_AluBSrc,
    input  logic              ex_branch_taken,
    output logic [3:0]        ex_ALUOp,
    output logic [4:0]        ex_BrOp,
    output logic              ex_AluASrc,
    output logic              ex_AluBSrc,
    output logic              mem_DMWr,
    output logic [2:0]        mem_DMCtrl,
    output logic [1:0]        mem_RUDataWrSrc,
    output logic              wb_RuWr,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        wb_RUDataWrSrc,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam logic [1:0]       SRC_MEM = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic [4:0]        br_op;
        logic [2:0]        dm_ctrl;
        logic [1:0]        wr_src;
        logic              ru_wr;
        logic              dm_wr;
        logic              alu_a_src;
        logic              alu_b_src;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_ctrl_t;

    typedef struct packed {
        logic [2:0]        dm_ctrl;
        logic [1:0]        wr_src;
        logic              ru_wr;
        logic              dm_wr;
        logic [REG_AW-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic [1:0]        wr_src;
        logic              ru_wr;
        logic [REG_AW-1:0] rd;
    } wb_ctrl_t;

    // Valid shift register: [1]=EX, [2]=MEM, [3]=WB.
    logic [3:1]      r_vld_pipe;
    ex_ctrl_t        r_ex;
    mem_ctrl_t       r_mem;
    wb_ctrl_t        r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ex_ctrl_t        w_id_bundle;
    ex_ctrl_t        w_ex_next;
    logic            w_ex_next_vld;
    logic            w_ex_is_load;
    logic            w_rs_hit;
    logic            w_stall;
    logic            w_flush;
    logic            w_mem_fwd_ok;
    logic            w_wb_fwd_ok;
    logic [1:0][REG_AW-1:0] w_ex_rs;
    logic [1:0][1:0]        w_fwd;

    always_comb begin
        w_id_bundle           = '0;
        w_id_bundle.alu_op    = id_ALUOp;
        w_id_bundle.br_op     = id_BrOp;
        w_id_bundle.dm_ctrl   = id_DMCtrl;
        w_id_bundle.wr_src    = id_RUDataWrSrc;
        w_id_bundle.ru_wr     = id_RuWr;
        w_id_bundle.dm_wr     = id_DMWr;
        w_id_bundle.alu_a_src = id_AluASrc;
        w_id_bundle.alu_b_src = id_AluBSrc;
        w_id_bundle.rd        = id_rd;
        // Unused sources are zeroed so they can never trigger forwarding.
        w_id_bundle.rs1       = id_uses_rs1 ? id_rs1 : '0;
        w_id_bundle.rs2       = id_uses_rs2 ? id_rs2 : '0;
    end

    assign w_ex_is_load = r_vld_pipe[1] && r_ex.ru_wr && (r_ex.wr_src == SRC_MEM)
                          && (r_ex.rd != '0);
    assign w_rs_hit     = (id_uses_rs1 && (id_rs1 == r_ex.rd))
                       || (id_uses_rs2 && (id_rs2 == r_ex.rd));
    assign w_flush      = r_vld_pipe[1] && ex_branch_taken && !hold;
    assign w_stall      = id_valid && w_ex_is_load && w_rs_hit && !w_flush && !hold;

    assign w_ex_next     = (w_stall || w_flush) ? '0 : w_id_bundle;
    assign w_ex_next_vld = id_valid && !w_stall && !w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            r_vld_pipe     <= {r_vld_pipe[2:1], w_ex_next_vld};
            r_ex           <= w_ex_next;
            r_mem.dm_ctrl  <= r_ex.dm_ctrl;
            r_mem.wr_src   <= r_ex.wr_src;
            r_mem.ru_wr    <= r_ex.ru_wr;
            r_mem.dm_wr    <= r_ex.dm_wr;
            r_mem.rd       <= r_ex.rd;
            r_wb.wr_src    <= r_mem.wr_src;
            r_wb.ru_wr     <= r_mem.ru_wr;
            r_wb.rd        <= r_mem.rd;
            if (w_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign w_mem_fwd_ok = r_vld_pipe[2] && r_mem.ru_wr && (r_mem.rd != '0);
    assign w_wb_fwd_ok  = r_vld_pipe[3] && r_wb.ru_wr && (r_wb.rd != '0);
    assign w_ex_rs      = {r_ex.rs2, r_ex.rs1};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        ctrl_fwd_sel #(.REG_AW(REG_AW)) u_sel (
            .i_mem_ok (w_mem_fwd_ok),
            .i_mem_rd (r_mem.rd),
            .i_wb_ok  (w_wb_fwd_ok),
            .i_wb_rd  (r_wb.rd),
            .i_rs     (w_ex_rs[g]),
            .o_sel    (w_fwd[g])
        );
    end

    assign fwd_a           = w_fwd[0];
    assign fwd_b           = w_fwd[1];
    assign ex_ALUOp        = r_ex.alu_op;
    assign ex_BrOp         = r_ex.br_op;
    assign ex_AluASrc      = r_ex.alu_a_src;
    assign ex_AluBSrc      = r_ex.alu_b_src;
    assign mem_DMWr        = r_mem.dm_wr;
    assign mem_DMCtrl      = r_mem.dm_ctrl;
    assign mem_RUDataWrSrc = r_mem.wr_src;
    assign wb_RuWr         = r_vld_pipe[3] && r_wb.ru_wr;
    assign wb_rd           = r_wb.rd;
    assign wb_RUDataWrSrc  = r_wb.wr_src;
    assign stall           = w_stall;
    assign flush           = w_flush;
    assign stall_count     = r_stall_cnt;
    assign flush_count     = r_flush_cnt;
endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Back end of the instruction decoder in the pipelined core.
- Takes the per-instruction control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and taken branches/jumps, and drives stall, flush and operand-forwarding selects.
- Sits between the decoder and the EX/MEM/WB datapath muxes. ImmSrc is consumed in ID and is not carried.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 16, width of the stall/flush performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- hold  in  1  data-memory wait; freezes all stage registers
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source
- id_ALUOp  in  4
- id_BrOp  in  5
- id_DMCtrl  in  3
- id_RUDataWrSrc  in  2  (00 ALU, 01 memory, 10 PC+4)
- id_RuWr, id_DMWr, id_AluASrc, id_AluBSrc  in  1 each
- ex_branch_taken  in  1  branch unit result for the EX instruction
- ex_ALUOp  out  4
- ex_BrOp  out  5
- ex_AluASrc, ex_AluBSrc  out  1 each
- mem_DMWr  out  1
- mem_DMCtrl  out  3
- mem_RUDataWrSrc  out  2
- wb_RuWr  out  1
- wb_rd  out  REG_AW
- wb_RUDataWrSrc  out  2
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 EX/MEM result, 10 WB result
- stall  out  1  hold PC and IF/ID
- flush  out  1  clear IF/ID
- stall_count, flush_count  out  CNT_W each

Behaviour:
- Reset (synchronous, rst=1 at posedge): all stage valids 0; all control fields, rd/rs fields and counters 0.
  - Combinational outputs therefore read 0: stall=0, flush=0, fwd_a=fwd_b=00.
  - Reset overrides hold and any in-flight instruction.
- Bubble: valid=0 with RuWr=0, DMWr=0, BrOp=0; all other fields 0.
- Stage advance (each posedge with hold=0): WB<=MEM, MEM<=EX, EX<=ID bundle.
  - Exception: when stall=1 or flush=1, EX<=bubble instead of the ID bundle.
  - EX also stores id_rs1/id_rs2, with the stored index forced to 0 when the corresponding uses flag is 0.
- hold=1: every stage register keeps its value. stall, flush and the counters are forced to 0 / held. Forwarding selects stay live.
- Load-use: stall is asserted combinationally when all of the following hold:
  - id_valid, ex_valid, ex_RuWr, ex_RUDataWrSrc==01, ex_rd!=0;
  - and either (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd);
  - and flush=0 and hold=0.
  - Latency: exactly one bubble per load-use pair.
- Flush: asserted when ex_valid, ex_branch_taken and hold=0.
  - Flush has priority over stall; both ID and IF instructions are discarded (two-instruction penalty).
  - Jumps (BrOp=10000) rely on the branch unit asserting ex_branch_taken.
- Forwarding for operand A, using the stored ex_rs1 (operand B is identical with ex_rs2):
  - 01 if mem_valid, mem_RuWr, mem_rd!=0 and mem_rd==ex_rs1;
  - else 10 if wb_valid, wb_RuWr, wb_rd!=0 and wb_rd==ex_rs1;
  - else 00.
  - MEM has priority over WB when both match.
  - x0 is never forwarded.
  - Forwarding is not gated by AluASrc; the datapath ignores fwd_a when AluASrc=1.
- Output mapping: wb_RuWr = wb_valid and wb_RuWr field, so a bubble never writes.
- Counters: +1 on each posedge where stall=1 (stall_count) or flush=1 (flush_count). Saturating at all-ones, no wrap.

Test Plan:
- Reset mid-stream: 3 valid instructions in flight, assert rst for 1 cycle -> next cycle all outputs 0, wb_RuWr=0, counters 0.
- Load-use: `lw x5` (RUDataWrSrc=01, rd=5) followed by `add x6,x5,x7` -> stall=1 for exactly one cycle; EX gets a bubble; the next cycle shows the add in EX with fwd_a=10; stall_count=1.
- Forward priority: `add x3`, `sub x3`, then `or x4,x3,x3` -> with the or in EX, fwd_a=fwd_b=01 (MEM wins). An instruction writing x0 followed by a reader of x0 -> fwd=00.
- Branch taken with simultaneous hazard: `beq` in EX with ex_branch_taken=1 while ID holds a load-use consumer -> flush=1, stall=0; EX next = bubble; flush_count=1, stall_count unchanged.
- Hold: assert hold for 3 cycles with a `sw` in MEM -> mem_DMWr stays 1 and all stages are frozen; stall/flush=0 even if a hazard condition is present; resumes advancing after release.
- Saturation: force 2^CNT_W+5 stall cycles -> stall_count=all-ones, no wrap.
